// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU opcodes, memory access sizes,
// and the EX-stage data-RAM request FSM states.
package core_pkg;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int MEM_OP_WIDTH = 3;

  // Bit positions inside the one-hot memory access size field
  localparam int MEM_OP_BYTE = 0;
  localparam int MEM_OP_HALF = 1;
  localparam int MEM_OP_WORD = 2;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASS2 = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACC  = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU for the EX stage.
module ex_alu
  import core_pkg::*;
(
  input  alu_op_e         opcode,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = src2[4:0];

  // Select the operation; unknown opcodes produce zero
  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:   result = src1 + src2;
      ALU_SUB:   result = src1 - src2;
      ALU_AND:   result = src1 & src2;
      ALU_OR:    result = src1 | src2;
      ALU_XOR:   result = src1 ^ src2;
      ALU_SLL:   result = src1 << shamt;
      ALU_SRL:   result = src1 >> shamt;
      ALU_SRA:   result = $unsigned($signed(src1) >>> shamt);
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (src1 < src2)};
      ALU_PASS2: result = src2;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: ALU, data-RAM request issue with store formatting,
// and the EX->MEM pipeline register.
module ex_stage
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_b,
  // ID -> EX
  output logic                    ex_pipe_ready,
  output logic                    ex_pipe_flush,
  input  logic                    ex_pipe_valid,
  input  logic [XLEN-1:0]         ex_pipe_pc,
  input  logic [XLEN-1:0]         ex_pipe_instruction,
  input  logic [3:0]              ex_pipe_alu_opcode,
  input  logic [XLEN-1:0]         ex_pipe_alu_src1,
  input  logic [XLEN-1:0]         ex_pipe_alu_src2,
  input  logic [XLEN-1:0]         ex_pipe_rs2_data,
  input  logic                    ex_pipe_mem_read,
  input  logic                    ex_pipe_mem_write,
  input  logic [MEM_OP_WIDTH-1:0] ex_pipe_mem_opcode,
  input  logic                    ex_pipe_unsign,
  input  logic                    ex_pipe_rd_write,
  input  logic [REG_AW-1:0]       ex_pipe_rd_addr,
  // EX -> MEM
  input  logic                    mem_pipe_ready,
  input  logic                    mem_pipe_flush,
  output logic                    mem_pipe_valid,
  output logic [XLEN-1:0]         mem_pipe_pc,
  output logic [XLEN-1:0]         mem_pipe_instruction,
  output logic [XLEN-1:0]         mem_pipe_alu_result,
  output logic                    mem_pipe_mem_read,
  output logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
  output logic                    mem_pipe_unsign,
  output logic                    mem_pipe_rd_write,
  output logic [REG_AW-1:0]       mem_pipe_rd_addr,
  // Forwarding to ID
  output logic                    ex_rd_write,
  output logic [REG_AW-1:0]       ex_rd_addr,
  output logic [XLEN-1:0]         ex_rd_wdata,
  output logic                    ex_mem_read,
  // Data RAM request
  output logic                    dram_req,
  output logic                    dram_write,
  output logic [XLEN-1:0]         dram_addr,
  output logic [XLEN-1:0]         dram_wdata,
  output logic [3:0]              dram_wstrb,
  input  logic                    dram_addr_ok
);

  ex_state_e       state, state_nxt;
  logic [XLEN-1:0] alu_result;
  logic            ex_valid, is_mem, ex_done;
  logic            req_start;
  logic [XLEN-1:0] fmt_wdata;
  logic [3:0]      fmt_wstrb;
  // Request fields captured when a request has to wait, so the RAM sees a
  // stable request for as long as it is stalling us.
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [3:0]      req_wstrb;
  logic            req_write;

  ex_alu u_alu (
    .opcode (alu_op_e'(ex_pipe_alu_opcode)),
    .src1   (ex_pipe_alu_src1),
    .src2   (ex_pipe_alu_src2),
    .result (alu_result)
  );

  assign ex_valid      = ex_pipe_valid & ~mem_pipe_flush;
  assign is_mem        = ex_pipe_mem_read | ex_pipe_mem_write;
  assign ex_pipe_flush = mem_pipe_flush;

  assign ex_rd_write = ex_pipe_valid & ex_pipe_rd_write;
  assign ex_rd_addr  = ex_pipe_rd_addr;
  assign ex_rd_wdata = alu_result;
  assign ex_mem_read = ex_pipe_valid & ex_pipe_mem_read;

  // Store data replication and byte strobes; loads write no bytes
  always_comb begin
    fmt_wdata = ex_pipe_rs2_data;
    fmt_wstrb = 4'b0000;
    if (ex_pipe_mem_write) begin
      if (ex_pipe_mem_opcode[MEM_OP_BYTE]) begin
        fmt_wdata = {4{ex_pipe_rs2_data[7:0]}};
        fmt_wstrb = 4'b0001 << alu_result[1:0];
      end else if (ex_pipe_mem_opcode[MEM_OP_HALF]) begin
        fmt_wdata = {2{ex_pipe_rs2_data[15:0]}};
        fmt_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
      end else begin
        fmt_wstrb = 4'b1111;
      end
    end
  end

  // Request strobe; rst_b gating keeps it low while reset is held
  always_comb begin
    dram_req = 1'b0;
    case (state)
      ST_IDLE: dram_req = rst_b & ex_valid & is_mem & mem_pipe_ready;
      ST_REQ:  dram_req = 1'b1;
      default: dram_req = 1'b0;
    endcase
  end

  assign req_start = (state == ST_IDLE) & dram_req & ~dram_addr_ok;

  assign dram_addr  = (state == ST_REQ) ? req_addr  : alu_result;
  assign dram_wdata = (state == ST_REQ) ? req_wdata : fmt_wdata;
  assign dram_wstrb = (state == ST_REQ) ? req_wstrb : fmt_wstrb;
  assign dram_write = (state == ST_REQ) ? req_write : ex_pipe_mem_write;

  // Next state: an issued request is held until accepted; flush only takes
  // effect once the RAM has taken the request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_start) state_nxt = ST_REQ;
      ST_REQ: begin
        if (dram_addr_ok) begin
          if (mem_pipe_flush || mem_pipe_ready) state_nxt = ST_IDLE;
          else                                  state_nxt = ST_ACC;
        end
      end
      ST_ACC:  if (mem_pipe_flush || mem_pipe_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ex_done = ~is_mem
                 | ((state == ST_IDLE) & dram_addr_ok)
                 | ((state == ST_REQ)  & dram_addr_ok)
                 | (state == ST_ACC);

  assign ex_pipe_ready = (mem_pipe_ready & ex_done) | ~ex_pipe_valid;

  // FSM state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the request fields on the cycle a request starts waiting
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_write <= 1'b0;
    end else if (req_start) begin
      req_addr  <= alu_result;
      req_wdata <= fmt_wdata;
      req_wstrb <= fmt_wstrb;
      req_write <= ex_pipe_mem_write;
    end
  end

  // EX->MEM pipeline register, advanced whenever MEM can accept
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_pipe_valid       <= 1'b0;
      mem_pipe_pc          <= '0;
      mem_pipe_instruction <= '0;
      mem_pipe_alu_result  <= '0;
      mem_pipe_mem_read    <= 1'b0;
      mem_pipe_mem_opcode  <= '0;
      mem_pipe_unsign      <= 1'b0;
      mem_pipe_rd_write    <= 1'b0;
      mem_pipe_rd_addr     <= '0;
    end else if (mem_pipe_ready) begin
      mem_pipe_valid       <= ex_valid & ex_done;
      mem_pipe_pc          <= ex_pipe_pc;
      mem_pipe_instruction <= ex_pipe_instruction;
      mem_pipe_alu_result  <= alu_result;
      mem_pipe_mem_read    <= ex_pipe_mem_read;
      mem_pipe_mem_opcode  <= ex_pipe_mem_opcode;
      mem_pipe_unsign      <= ex_pipe_unsign;
      mem_pipe_rd_write    <= ex_pipe_rd_write;
      mem_pipe_rd_addr     <= ex_pipe_rd_addr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU results, store formatting, request FSM
// stalls, accept-while-blocked, flush during request and async reset.
module tb_ex_stage;
  import core_pkg::*;

  logic            clk, rst_b;
  logic            ex_pipe_ready, ex_pipe_flush, ex_pipe_valid;
  logic [31:0]     ex_pipe_pc, ex_pipe_instruction;
  logic [3:0]      ex_pipe_alu_opcode;
  logic [31:0]     ex_pipe_alu_src1, ex_pipe_alu_src2, ex_pipe_rs2_data;
  logic            ex_pipe_mem_read, ex_pipe_mem_write;
  logic [2:0]      ex_pipe_mem_opcode;
  logic            ex_pipe_unsign, ex_pipe_rd_write;
  logic [4:0]      ex_pipe_rd_addr;
  logic            mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
  logic [31:0]     mem_pipe_pc, mem_pipe_instruction, mem_pipe_alu_result;
  logic            mem_pipe_mem_read;
  logic [2:0]      mem_pipe_mem_opcode;
  logic            mem_pipe_unsign, mem_pipe_rd_write;
  logic [4:0]      mem_pipe_rd_addr;
  logic            ex_rd_write;
  logic [4:0]      ex_rd_addr;
  logic [31:0]     ex_rd_wdata;
  logic            ex_mem_read;
  logic            dram_req, dram_write;
  logic [31:0]     dram_addr, dram_wdata;
  logic [3:0]      dram_wstrb;
  logic            dram_addr_ok;

  int vectors = 0;
  int miscompares = 0;

  ex_stage dut (
    .clk(clk), .rst_b(rst_b),
    .ex_pipe_ready(ex_pipe_ready), .ex_pipe_flush(ex_pipe_flush),
    .ex_pipe_valid(ex_pipe_valid), .ex_pipe_pc(ex_pipe_pc),
    .ex_pipe_instruction(ex_pipe_instruction),
    .ex_pipe_alu_opcode(ex_pipe_alu_opcode),
    .ex_pipe_alu_src1(ex_pipe_alu_src1), .ex_pipe_alu_src2(ex_pipe_alu_src2),
    .ex_pipe_rs2_data(ex_pipe_rs2_data),
    .ex_pipe_mem_read(ex_pipe_mem_read), .ex_pipe_mem_write(ex_pipe_mem_write),
    .ex_pipe_mem_opcode(ex_pipe_mem_opcode), .ex_pipe_unsign(ex_pipe_unsign),
    .ex_pipe_rd_write(ex_pipe_rd_write), .ex_pipe_rd_addr(ex_pipe_rd_addr),
    .mem_pipe_ready(mem_pipe_ready), .mem_pipe_flush(mem_pipe_flush),
    .mem_pipe_valid(mem_pipe_valid), .mem_pipe_pc(mem_pipe_pc),
    .mem_pipe_instruction(mem_pipe_instruction),
    .mem_pipe_alu_result(mem_pipe_alu_result),
    .mem_pipe_mem_read(mem_pipe_mem_read),
    .mem_pipe_mem_opcode(mem_pipe_mem_opcode),
    .mem_pipe_unsign(mem_pipe_unsign), .mem_pipe_rd_write(mem_pipe_rd_write),
    .mem_pipe_rd_addr(mem_pipe_rd_addr),
    .ex_rd_write(ex_rd_write), .ex_rd_addr(ex_rd_addr),
    .ex_rd_wdata(ex_rd_wdata), .ex_mem_read(ex_mem_read),
    .dram_req(dram_req), .dram_write(dram_write), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_wstrb(dram_wstrb),
    .dram_addr_ok(dram_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] opc, input logic [31:0] s1, input logic [31:0] s2);
    ex_pipe_valid      = 1'b1;
    ex_pipe_alu_opcode = opc;
    ex_pipe_alu_src1   = s1;
    ex_pipe_alu_src2   = s2;
  endtask

  initial begin
    rst_b = 1'b0;
    ex_pipe_valid = 1'b1; ex_pipe_pc = 32'h100; ex_pipe_instruction = 32'h13;
    ex_pipe_alu_opcode = ALU_ADD; ex_pipe_alu_src1 = 32'h10; ex_pipe_alu_src2 = 0;
    ex_pipe_rs2_data = 0; ex_pipe_mem_read = 1'b1; ex_pipe_mem_write = 1'b0;
    ex_pipe_mem_opcode = 3'b100; ex_pipe_unsign = 1'b0; ex_pipe_rd_write = 1'b1;
    ex_pipe_rd_addr = 5'd7; mem_pipe_ready = 1'b1; mem_pipe_flush = 1'b0;
    dram_addr_ok = 1'b0;

    // Reset: valid load present but no request may be made
    tick(); tick();
    chk("rst_dram_req", {31'b0, dram_req}, 32'h0);
    chk("rst_mem_valid", {31'b0, mem_pipe_valid}, 32'h0);
    chk("rst_alu_result", mem_pipe_alu_result, 32'h0);
    ex_pipe_valid = 1'b0; ex_pipe_mem_read = 1'b0;
    rst_b = 1'b1;
    tick();

    // ADD overflow wraps, no memory op
    op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    #1;
    chk("add_fwd", ex_rd_wdata, 32'h8000_0000);
    chk("add_no_req", {31'b0, dram_req}, 32'h0);
    chk("add_ready", {31'b0, ex_pipe_ready}, 32'h1);
    tick();
    chk("add_mem_valid", {31'b0, mem_pipe_valid}, 32'h1);
    chk("add_mem_result", mem_pipe_alu_result, 32'h8000_0000);
    chk("add_mem_rd", {27'b0, mem_pipe_rd_addr}, 32'h7);

    // MEM stalled with a non-memory op: EX holds, register unchanged
    op(ALU_ADD, 32'h5, 32'h5);
    mem_pipe_ready = 1'b0;
    #1;
    chk("hold_ex_ready", {31'b0, ex_pipe_ready}, 32'h0);
    tick();
    chk("hold_result", mem_pipe_alu_result, 32'h8000_0000);
    chk("hold_valid", {31'b0, mem_pipe_valid}, 32'h1);
    mem_pipe_ready = 1'b1;

    // ALU opcode table
    op(ALU_SUB, 32'h0, 32'h1);               #1; chk("sub", ex_rd_wdata, 32'hFFFF_FFFF);
    op(ALU_SRA, 32'h8000_0000, 32'h24);      #1; chk("sra", ex_rd_wdata, 32'hF800_0000);
    op(ALU_SRL, 32'h8000_0000, 32'h4);       #1; chk("srl", ex_rd_wdata, 32'h0800_0000);
    op(ALU_SLL, 32'h1, 32'h3F);              #1; chk("sll", ex_rd_wdata, 32'h8000_0000);
    op(ALU_SLT, 32'hFFFF_FFFF, 32'h1);       #1; chk("slt", ex_rd_wdata, 32'h1);
    op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);      #1; chk("sltu", ex_rd_wdata, 32'h0);
    op(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00); #1; chk("xor", ex_rd_wdata, 32'h0FF0_0FF0);
    op(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00); #1; chk("and", ex_rd_wdata, 32'hF000_F000);
    op(ALU_OR, 32'hF0F0_F0F0, 32'h0F00_0000);  #1; chk("or", ex_rd_wdata, 32'hFFF0_F0F0);
    op(ALU_PASS2, 32'h1234, 32'hCAFE_F00D);  #1; chk("pass2", ex_rd_wdata, 32'hCAFE_F00D);
    tick();

    // SB to 0x1003, accepted immediately
    op(ALU_ADD, 32'h1000, 32'h3);
    ex_pipe_mem_write = 1'b1; ex_pipe_mem_opcode = 3'b001; ex_pipe_rs2_data = 32'h1234_56AB;
    ex_pipe_rd_write = 1'b0; dram_addr_ok = 1'b1;
    #1;
    chk("sb_req", {31'b0, dram_req}, 32'h1);
    chk("sb_write", {31'b0, dram_write}, 32'h1);
    chk("sb_addr", dram_addr, 32'h1003);
    chk("sb_wstrb", {28'b0, dram_wstrb}, 32'h8);
    chk("sb_wdata", dram_wdata, 32'hABAB_ABAB);
    chk("sb_ready", {31'b0, ex_pipe_ready}, 32'h1);
    tick();
    chk("sb_mem_valid", {31'b0, mem_pipe_valid}, 32'h1);
    chk("sb_mem_read", {31'b0, mem_pipe_mem_read}, 32'h0);

    // SH to 0x1002
    op(ALU_ADD, 32'h1000, 32'h2);
    ex_pipe_mem_opcode = 3'b010; ex_pipe_rs2_data = 32'hFFFF_1234;
    #1;
    chk("sh_wstrb", {28'b0, dram_wstrb}, 32'hC);
    chk("sh_wdata", dram_wdata, 32'h1234_1234);
    tick();

    // LW to 0x2000 with addr_ok three cycles late
    op(ALU_ADD, 32'h2000, 32'h0);
    ex_pipe_mem_write = 1'b0; ex_pipe_mem_read = 1'b1; ex_pipe_mem_opcode = 3'b100;
    ex_pipe_rd_write = 1'b1; ex_pipe_rd_addr = 5'd9; dram_addr_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lw_wait_req", {31'b0, dram_req}, 32'h1);
      chk("lw_wait_addr", dram_addr, 32'h2000);
      chk("lw_wait_wstrb", {28'b0, dram_wstrb}, 32'h0);
      chk("lw_wait_ready", {31'b0, ex_pipe_ready}, 32'h0);
      chk("lw_ex_mem_read", {31'b0, ex_mem_read}, 32'h1);
      tick();
      chk("lw_wait_valid", {31'b0, mem_pipe_valid}, 32'h0);
    end
    dram_addr_ok = 1'b1;
    #1;
    chk("lw_ok_req", {31'b0, dram_req}, 32'h1);
    chk("lw_ok_ready", {31'b0, ex_pipe_ready}, 32'h1);
    tick();
    chk("lw_mem_valid", {31'b0, mem_pipe_valid}, 32'h1);
    chk("lw_mem_read", {31'b0, mem_pipe_mem_read}, 32'h1);
    chk("lw_mem_rd", {27'b0, mem_pipe_rd_addr}, 32'h9);
    ex_pipe_valid = 1'b0; dram_addr_ok = 1'b0;
    #1;
    chk("lw_idle_req", {31'b0, dram_req}, 32'h0);
    tick();

    // LH accepted while MEM is blocked: ACC, then advance with no new request
    op(ALU_ADD, 32'h3000, 32'h2);
    ex_pipe_mem_opcode = 3'b010; ex_pipe_unsign = 1'b1;
    #1;
    chk("lh_req0", {31'b0, dram_req}, 32'h1);
    tick();
    mem_pipe_ready = 1'b0; dram_addr_ok = 1'b1;
    #1;
    chk("lh_req1", {31'b0, dram_req}, 32'h1);
    chk("lh_ready1", {31'b0, ex_pipe_ready}, 32'h0);
    tick();
    dram_addr_ok = 1'b0;
    #1;
    chk("lh_acc_req", {31'b0, dram_req}, 32'h0);
    chk("lh_acc_ready", {31'b0, ex_pipe_ready}, 32'h0);
    tick();
    chk("lh_acc_valid", {31'b0, mem_pipe_valid}, 32'h0);
    mem_pipe_ready = 1'b1;
    #1;
    chk("lh_go_req", {31'b0, dram_req}, 32'h0);
    chk("lh_go_ready", {31'b0, ex_pipe_ready}, 32'h1);
    tick();
    chk("lh_mem_valid", {31'b0, mem_pipe_valid}, 32'h1);
    chk("lh_mem_op", {29'b0, mem_pipe_mem_opcode}, 32'h2);
    chk("lh_mem_unsign", {31'b0, mem_pipe_unsign}, 32'h1);
    chk("lh_mem_addr", mem_pipe_alu_result, 32'h3002);
    ex_pipe_valid = 1'b0; ex_pipe_unsign = 1'b0;
    tick();

    // Flush during REQ: request held until accepted, nothing reaches MEM
    op(ALU_ADD, 32'h4000, 32'h0);
    ex_pipe_mem_read = 1'b0; ex_pipe_mem_write = 1'b1; ex_pipe_mem_opcode = 3'b100;
    tick();
    mem_pipe_flush = 1'b1;
    #1;
    chk("fl_req", {31'b0, dram_req}, 32'h1);
    chk("fl_pass", {31'b0, ex_pipe_flush}, 32'h1);
    chk("fl_wstrb", {28'b0, dram_wstrb}, 32'hF);
    tick();
    chk("fl_valid0", {31'b0, mem_pipe_valid}, 32'h0);
    #1;
    chk("fl_req_held", {31'b0, dram_req}, 32'h1);
    dram_addr_ok = 1'b1;
    tick();
    chk("fl_valid1", {31'b0, mem_pipe_valid}, 32'h0);
    mem_pipe_flush = 1'b0; dram_addr_ok = 1'b0; ex_pipe_valid = 1'b0;
    #1;
    chk("fl_idle", {31'b0, dram_req}, 32'h0);
    tick();

    // Async reset while in REQ
    op(ALU_ADD, 32'h5000, 32'h4);
    ex_pipe_mem_write = 1'b0; ex_pipe_mem_read = 1'b1;
    tick();
    #1;
    chk("rr_req", {31'b0, dram_req}, 32'h1);
    chk("rr_result", mem_pipe_alu_result, 32'h5004);
    rst_b = 1'b0;
    #1;
    chk("rr_req_off", {31'b0, dram_req}, 32'h0);
    chk("rr_valid", {31'b0, mem_pipe_valid}, 32'h0);
    chk("rr_result_clr", mem_pipe_alu_result, 32'h0);
    ex_pipe_valid = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    chk("rr_idle", {31'b0, dram_req}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32 five-stage pipeline, sitting between ID and MEM. It computes the ALU result and issues the data-RAM address/write request for loads and stores. It also holds the EX→MEM pipeline register, whose outputs feed the MEM stage's `mem_pipe_*` inputs. Branch resolution happens in ID and is outside this block.

## Interface
- Parameters: none.
  - `XLEN` = 32, `REG_AW` = 5 and `MEM_OP_WIDTH` = 3 come from the shared headers.
  - `MEM_OP_WIDTH` is one-hot, with bits BYTE / HALF / WORD.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock
  - `rst_b`  in  1  asynchronous, active-low reset
- ID→EX pipeline:
  - `ex_pipe_ready`  out  1  EX accepts a new instruction this cycle
  - `ex_pipe_flush`  out  1  pass-through of `mem_pipe_flush`
  - `ex_pipe_valid`  in  1  instruction present in EX
  - `ex_pipe_pc`, `ex_pipe_instruction`  in  XLEN  carried through to MEM
  - `ex_pipe_alu_opcode`  in  4  ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASS2
  - `ex_pipe_alu_src1`, `ex_pipe_alu_src2`  in  XLEN  operands, already muxed and forwarded
  - `ex_pipe_rs2_data`  in  XLEN  store data
  - `ex_pipe_mem_read`, `ex_pipe_mem_write`  in  1  load / store
  - `ex_pipe_mem_opcode`  in  MEM_OP_WIDTH  access size; `ex_pipe_unsign`  in  1  unsigned load
  - `ex_pipe_rd_write`  in  1  and `ex_pipe_rd_addr`  in  REG_AW  destination register
- EX→MEM pipeline:
  - `mem_pipe_ready`  in  1  MEM can accept
  - `mem_pipe_flush`  in  1  kill EX and younger stages
  - `mem_pipe_valid`  out  1
  - `mem_pipe_pc`, `mem_pipe_instruction`, `mem_pipe_alu_result`  out  XLEN
  - `mem_pipe_mem_read`  out  1
  - `mem_pipe_mem_opcode`  out  MEM_OP_WIDTH
  - `mem_pipe_unsign`, `mem_pipe_rd_write`  out  1
  - `mem_pipe_rd_addr`  out  REG_AW
- Forwarding to ID:
  - `ex_rd_write`  out  1  and `ex_rd_addr`  out  REG_AW
  - `ex_rd_wdata`  out  XLEN  the ALU result
  - `ex_mem_read`  out  1  used for load-use stall
- Data RAM request:
  - `dram_req`  out  1  and `dram_write`  out  1
  - `dram_addr`, `dram_wdata`  out  XLEN
  - `dram_wstrb`  out  4
  - `dram_addr_ok`  in  1  request accepted

## Operation
- `ex_valid` = `ex_pipe_valid & ~mem_pipe_flush`.
- `is_mem` = `mem_read | mem_write`.
- ALU:
  - Shifts use `src2[4:0]`.
  - SLT and SLTU produce 0 or 1, zero-extended.
  - ADD and SUB wrap modulo 2^32.
  - `dram_addr` = the ALU result; the ID stage sets ADD for all memory operations.
- Store formatting:
  - Byte: `wdata` = the low byte replicated ×4; `wstrb` = `4'b0001 << addr[1:0]`.
  - Half: `wdata` = the low half replicated ×2; `wstrb` = `addr[1]` ? `1100` : `0011`.
  - Word: `wstrb` = `1111`.
  - Loads drive `wstrb` = 0.
  - Alignment is the compiler's responsibility and is not checked.
- Request FSM (registered state):
  - IDLE: `dram_req` = `ex_valid & is_mem & mem_pipe_ready`.
    - With `addr_ok` and `mem_pipe_ready` → stay in IDLE; the instruction advances.
    - With `req` and no `addr_ok` → REQ.
  - REQ: `dram_req` = 1, with address, data, strobe and write held stable (EX is stalled).
    - `addr_ok` and `mem_pipe_ready` → IDLE, advance.
    - `addr_ok` and not `mem_pipe_ready` → ACC.
    - `addr_ok` and `mem_pipe_flush` → IDLE, instruction dropped.
    - A request is never withdrawn before `addr_ok`.
  - ACC: `dram_req` = 0; wait for `mem_pipe_ready`, then advance → IDLE. `mem_pipe_flush` → IDLE.
- Completion and handshake:
  - `ex_done` = `~is_mem | (state==IDLE & addr_ok) | (state==REQ & addr_ok) | state==ACC`.
  - `ex_pipe_ready` = `mem_pipe_ready & ex_done`, or `~ex_pipe_valid`.
- Pipeline register:
  - When `mem_pipe_ready`: `mem_pipe_valid` <= `ex_valid & ex_done`.
  - All data fields load whenever `mem_pipe_ready`.
- Forwarding outputs are combinational from the EX inputs, qualified by `ex_pipe_valid`.

## Timing
- Reset values:
  - All `mem_pipe_*` outputs are 0; FSM state is IDLE.
  - `dram_req` is 0 during reset, because `ex_pipe_valid` is ignored while `rst_b` is low.
- Latency: one cycle EX→MEM when `addr_ok` is returned in the same cycle as `req`. Each cycle without `addr_ok` adds one stall cycle.
- The load's `dram_data_ok` returns in the cycle the load is valid in MEM; that phase is owned by the MEM stage.
- Flush while in REQ:
  - The request stays asserted until `addr_ok`.
  - `mem_pipe_valid` stays 0.
  - A store accepted this way still commits; the flush source must not flush past an accepted store.
- `mem_pipe_ready` low with no memory operation: EX holds, `ex_pipe_ready` = 0, and the pipeline register keeps its value.
- Reset asserted mid-REQ: the FSM returns to IDLE immediately; the RAM side is reset by the same `rst_b`.

## Structure
- `core_pkg` holds:
  - the ALU opcode enum (4 bits);
  - the `MEM_OP_BYTE`, `MEM_OP_HALF` and `MEM_OP_WORD` indices;
  - the FSM state enum {IDLE, REQ, ACC}.
- Sub-module `ex_alu`: purely combinational, with `opcode`, `src1`, `src2` → `result`.
- Everything else (FSM, store formatter, pipeline register) lives in `ex_stage`.

## Test plan
- ADD `src1` = `0x7FFFFFFF`, `src2` = 1, no memory operation, `mem_pipe_ready` = 1 → next cycle `mem_pipe_valid` = 1, `alu_result` = `0x80000000`, and no `dram_req`.
- SB with `addr` = `0x1003`, `rs2` = `0xAB` → `wstrb` = `1000`, `wdata` = `0xABABABAB`, `dram_write` = 1; `addr_ok` in the same cycle → `mem_pipe_valid` the next cycle.
- LW with `addr_ok` delayed 3 cycles → `dram_req` held for 4 cycles with a stable address, `ex_pipe_ready` = 0 for 3 cycles, then `mem_pipe_valid` = 1 and `mem_pipe_mem_read` = 1.
- LH accepted while `mem_pipe_ready` = 0 → FSM enters ACC and `dram_req` drops; when `mem_pipe_ready` rises, the load advances with no second request.
- `mem_pipe_flush` during REQ → `dram_req` held until `addr_ok`, `mem_pipe_valid` stays 0, and the FSM returns to IDLE.
- `rst_b` low while in REQ → `dram_req` = 0 and `mem_pipe_valid` = 0 asynchronously.
